// File: rtl/fifo_rd_unpack_if.sv
// fifo_rd_unpack_if: FIFO read port and byte stream bundle of the read-side unpacker
interface fifo_rd_unpack_if #(
  parameter int DATA_W = 64,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 16
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_vld;
  logic              fifo_rd_en;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_vld;
  logic              byte_rdy;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;
  logic              err_stray;
  modport slave (
    input  fifo_empty, fifo_dout, fifo_vld, byte_rdy,
    output fifo_rd_en, byte_out, byte_vld, busy, word_cnt, err_stray
  );
  modport master (
    output fifo_empty, fifo_dout, fifo_vld, byte_rdy,
    input  fifo_rd_en, byte_out, byte_vld, busy, word_cnt, err_stray
  );
endinterface

// File: rtl/fifo_rd_unpack.sv
// fifo_rd_unpack: reads one FIFO word at a time and serialises it as a valid/ready byte stream
module fifo_rd_unpack #(
  parameter int DATA_W    = 64,
  parameter int BYTE_W    = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input logic            rd_clk,
  input logic            rst_n,
  fifo_rd_unpack_if.slave bus
);
  localparam int N     = DATA_W / BYTE_W;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nxt;
  logic [IDX_W-1:0]  idx;
  function automatic logic [BYTE_W-1:0] head(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1 -: BYTE_W] : w[BYTE_W-1:0];
  endfunction
  // word with the byte just sent shifted out, so the next byte is always at the head
  always_comb sh_nxt = (MSB_FIRST != 0) ? sh << BYTE_W : sh >> BYTE_W;
  // read/serialise FSM; the FIFO is re-read straight from the last byte to skip an idle cycle
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sh             <= '0;
      idx            <= '0;
      bus.fifo_rd_en <= 1'b0;
      bus.byte_out   <= '0;
      bus.byte_vld   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.word_cnt   <= '0;
      bus.err_stray  <= 1'b0;
    end else begin
      bus.fifo_rd_en <= 1'b0;
      if (bus.fifo_vld && state != WAIT) bus.err_stray <= 1'b1;
      case (state)
        IDLE: if (!bus.fifo_empty) begin
          bus.fifo_rd_en <= 1'b1;
          bus.busy       <= 1'b1;
          state          <= WAIT;
        end
        WAIT: if (bus.fifo_vld) begin
          sh           <= bus.fifo_dout;
          idx          <= '0;
          bus.byte_out <= head(bus.fifo_dout);
          bus.byte_vld <= 1'b1;
          state        <= SEND;
        end
        SEND: if (bus.byte_rdy) begin
          if (idx != LAST) begin
            idx          <= idx + 1'b1;
            sh           <= sh_nxt;
            bus.byte_out <= head(sh_nxt);
          end else begin
            bus.word_cnt <= bus.word_cnt + 1'b1;
            bus.byte_vld <= 1'b0;
            if (!bus.fifo_empty) begin
              bus.fifo_rd_en <= 1'b1;
              state          <= WAIT;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fifo_rd_unpack.md
Name: fifo_rd_unpack

Overview:
- Read-side consumer for the 8-to-64 width-converting FIFO.
- Pulls 64-bit words from the FIFO read port, one outstanding read at a time.
- Serialises each word into eight bytes on a valid/ready byte stream for downstream logic (UART/SPI transmit path).
- Runs entirely in the read clock domain.

Parameters:
- DATA_W, 64: FIFO word width; must equal BYTE_W*8.
- BYTE_W, 8: output byte width.
- MSB_FIRST, 1: 1 = bits [63:56] sent first; 0 = bits [7:0] sent first.
- CNT_W, 16: width of the completed-word counter.

Ports:
- rd_clk  input  1  read-domain clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag, read domain.
- fifo_dout  input  DATA_W  registered FIFO read data.
- fifo_vld  input  1  FIFO read-data valid, asserted by the FIFO some cycles after fifo_rd_en.
- fifo_rd_en  output  1  single-cycle FIFO read request, registered.
- byte_out  output  BYTE_W  current output byte.
- byte_vld  output  1  byte_out valid.
- byte_rdy  input  1  downstream ready.
- busy  output  1  high in any state other than IDLE.
- word_cnt  output  CNT_W  count of fully transmitted words.
- err_stray  output  1  sticky flag: fifo_vld seen while no read was outstanding.

Behaviour:
- Reset is asynchronous, active-low, on rst_n. Clock is rd_clk.
- Reset values: state = IDLE; fifo_rd_en = 0; byte_vld = 0; byte_out = 0; busy = 0; word_cnt = 0; err_stray = 0; shift register = 0; byte index = 0.

State IDLE:
- If fifo_empty = 0: register fifo_rd_en = 1 for exactly one cycle, then go to WAIT.
- Otherwise stay in IDLE.

State WAIT:
- fifo_rd_en = 0.
- On fifo_vld = 1: capture fifo_dout into the shift register, set index = 0, go to SEND. byte_vld rises on the next cycle.
- No timeout; stays in WAIT indefinitely.

State SEND:
- byte_vld = 1.
- byte_out = byte[index]. With MSB_FIRST = 1, byte 0 is bits [63:56]; otherwise byte 0 is bits [7:0].
- Handshake occurs when byte_vld = 1 and byte_rdy = 1. Then:
  - If index < 7: index increments; the next byte is presented in the following cycle.
  - If index = 7: word_cnt increments. If fifo_empty = 0 in that cycle, pulse fifo_rd_en and go to WAIT; otherwise go to IDLE with byte_vld = 0.
- byte_vld held with byte_rdy = 0: byte_out and byte_vld stay stable until the handshake. byte_vld never drops without a handshake.

Boundary conditions:
- fifo_vld in IDLE or SEND: data ignored, err_stray set to 1 and held until reset.
- fifo_empty rising while in WAIT: no effect, because the read was already issued.
- word_cnt wraps from all-ones to 0 with no flag.
- Only one read is ever outstanding; fifo_rd_en is never asserted in WAIT.
- Reset mid-word: remaining bytes are discarded, word_cnt is not incremented, and the FIFO is not re-read for the lost word.

Throughput:
- Best case is one byte per cycle within a word.
- Inter-word gap is the FIFO read latency plus one cycle.
- Latency from fifo_vld to first byte_vld: 1 cycle.

Test Plan:
- Single word, MSB_FIRST = 1: FIFO holds 64'h0102030405060708, byte_rdy held at 1 → one fifo_rd_en pulse; bytes 01,02,…,08 on 8 consecutive cycles; word_cnt = 1; busy low after the last byte.
- Byte order, MSB_FIRST = 0: same word → bytes 08,07,…,01.
- Backpressure: byte_rdy low 5 cycles on byte 3 → byte_out stays 04 with byte_vld = 1 throughout; sequence completes intact; no extra fifo_rd_en.
- Back-to-back: FIFO holds 3 words, byte_rdy = 1 → exactly 3 fifo_rd_en pulses, never two in WAIT; 24 bytes in order; word_cnt = 3; returns to IDLE once fifo_empty = 1.
- Empty/stray: fifo_empty = 1 for 20 cycles → no fifo_rd_en and no byte_vld. Then a forced fifo_vld pulse in IDLE → err_stray = 1 and stays 1; no bytes emitted.
- Reset mid-word: assert rst_n low after byte 4 → byte_vld, busy, and word_cnt return to 0 asynchronously. After release, the next FIFO word is sent from its byte 0.
